// File: rtl/cpu_pkg.sv
// Shared definitions for the instruction fetch front end.
package cpu_pkg;

    localparam int          INST_W        = 32;
    localparam logic [31:0] RESET_PC_DFLT = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        DRAIN = 2'd1,
        HALT  = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_buffer.sv
// Small synchronous FIFO with flush. It holds request PCs awaiting their
// response, and {pc, inst} pairs awaiting decode.
module fetch_buffer #(
    parameter  int W     = 64,
    parameter  int DEPTH = 2,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    input  logic          flush,
    output logic [W-1:0]  head,
    output logic [CW-1:0] count
);
    localparam int            PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] rd_q, rd_d;
    logic [PW-1:0] wr_q, wr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          do_push;
    logic          do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + PW'(1);
    endfunction

    // Pointer/occupancy next state; a push on a full FIFO is accepted only alongside a pop, flush wins.
    always_comb begin
        do_pop  = pop && (cnt_q != '0);
        do_push = push && ((cnt_q != FULL) || do_pop);
        rd_d    = do_pop  ? ptr_inc(rd_q) : rd_q;
        wr_d    = do_push ? ptr_inc(wr_q) : wr_q;
        cnt_d   = cnt_q + CW'(do_push) - CW'(do_pop);
        if (flush) begin
            rd_d  = '0;
            wr_d  = '0;
            cnt_d = '0;
        end
    end

    // Control state, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage carries no reset; validity comes from the count.
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem_q[wr_q] <= push_data;
        end
    end

    assign head  = mem_q[rd_q];
    assign count = cnt_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: owns the PC, issues in-order memory requests,
// buffers returned words for decode and squashes wrong-path fetches on redirect.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DFLT,
    parameter int          DEPTH    = 2
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [31:0]       imem_req_addr,
    input  logic              imem_resp_valid,
    input  logic [INST_W-1:0] imem_resp_data,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [INST_W-1:0] inst_data,
    output logic [31:0]       inst_pc,
    output logic              fetch_fault
);
    localparam int          CW  = $clog2(DEPTH + 1);
    localparam logic [CW:0] CAP = DEPTH[CW:0];

    fetch_state_t      state_q, state_d;
    logic [31:0]       pc_q, pc_d;
    logic [CW-1:0]     drop_q, drop_d;
    logic              fault_q, fault_d;

    logic [CW-1:0]     out_cnt;     // outstanding requests = entries in the request-PC FIFO
    logic [CW-1:0]     out_d;
    logic [CW-1:0]     buf_cnt;
    logic [31:0]       pcq_head;
    logic [2*INST_W-1:0] buf_head;
    logic [CW:0]       used;
    logic              req_hs;
    logic              resp;
    logic              buf_push;
    logic              buf_pop;
    logic              buf_flush;

    // Request PCs in issue order; responses return in the same order.
    fetch_buffer #(.W(32), .DEPTH(DEPTH)) u_pcq (
        .clk       (clk),
        .rst       (rst),
        .push      (req_hs),
        .push_data (pc_q),
        .pop       (resp),
        .flush     (1'b0),
        .head      (pcq_head),
        .count     (out_cnt)
    );

    // Instruction buffer feeding decode.
    fetch_buffer #(.W(2 * INST_W), .DEPTH(DEPTH)) u_ibuf (
        .clk       (clk),
        .rst       (rst),
        .push      (buf_push),
        .push_data ({pcq_head, imem_resp_data}),
        .pop       (buf_pop),
        .flush     (buf_flush),
        .head      (buf_head),
        .count     (buf_cnt)
    );

    // Credit check, handshakes, drop accounting and next state; a redirect overrides everything else.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        drop_d    = drop_q;
        fault_d   = fault_q;
        buf_flush = 1'b0;

        inst_valid = (buf_cnt != '0) && !redirect_valid && (state_q != HALT);
        buf_pop    = inst_valid && inst_ready;
        // An entry leaving this cycle frees its credit immediately so a 1-cycle memory streams.
        used           = {1'b0, out_cnt} + {1'b0, buf_cnt} - (CW + 1)'(buf_pop);
        imem_req_valid = !rst && (state_q == FETCH) && (used < CAP);
        req_hs         = imem_req_valid && imem_req_ready;
        resp           = imem_resp_valid && (out_cnt != '0);
        out_d          = out_cnt + CW'(req_hs) - CW'(resp);
        buf_push       = resp && (drop_q == '0) && (state_q == FETCH);

        if (resp && (drop_q != '0)) begin
            drop_d = drop_q - CW'(1);
        end
        if (req_hs) begin
            pc_d = pc_q + 32'd4;
        end
        if ((state_q == DRAIN) && (drop_d == '0)) begin
            state_d = FETCH;
        end

        if (redirect_valid && (state_q != HALT)) begin
            buf_flush = 1'b1;
            if (redirect_pc[1:0] != 2'b00) begin
                fault_d = 1'b1;
                state_d = HALT;
            end else begin
                pc_d    = redirect_pc;
                drop_d  = out_d;
                state_d = (out_d != '0) ? DRAIN : FETCH;
            end
        end
    end

    // Architectural PC, state, drop count and sticky fault.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            drop_q  <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            drop_q  <= drop_d;
            fault_q <= fault_d;
        end
    end

    assign imem_req_addr = pc_q;
    assign inst_data     = inst_valid ? buf_head[INST_W-1:0] : '0;
    assign inst_pc       = inst_valid ? buf_head[2*INST_W-1:INST_W] : '0;
    assign fetch_fault   = fault_q;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
    import cpu_pkg::*;

    localparam int          DEPTH = 2;
    localparam logic [31:0] RPC   = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        fetch_fault;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    fetch_unit #(.RESET_PC(RPC), .DEPTH(DEPTH)) dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .inst_data       (inst_data),
        .inst_pc         (inst_pc),
        .fetch_fault     (fetch_fault)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
    endfunction

    // ---------------- instruction memory model ----------------
    typedef struct { int due; logic [31:0] addr; } mreq_t;
    mreq_t mq[$];
    int    last_due   = 0;
    int    lat_min    = 1;
    int    lat_max    = 1;
    bit    rand_ready = 1'b0;

    initial begin
        imem_req_ready  = 1'b1;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        forever begin
            @(posedge clk); #1;
            imem_req_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (rst) begin
                mq.delete();
                last_due        = 0;
                imem_resp_valid = 1'b0;
                imem_resp_data  = '0;
            end else if (mq.size() > 0 && mq[0].due <= cyc) begin
                imem_resp_valid = 1'b1;
                imem_resp_data  = mem_word(mq[0].addr);
                void'(mq.pop_front());
            end else begin
                imem_resp_valid = 1'b0;
                imem_resp_data  = $urandom;
            end
            @(negedge clk);
            if (!rst && imem_req_valid && imem_req_ready) begin
                int d;
                d = cyc + $urandom_range(lat_min, lat_max);
                if (d <= last_due) d = last_due + 1;
                last_due = d;
                mq.push_back('{d, imem_req_addr});
            end
        end
    end

    // ---------------- transaction-level reference model ----------------
    logic [31:0] exp_req_pc, exp_dlv_pc;
    int  m_out, m_buf, stale, last_stale_cyc;
    bit  halted, gap_wait;
    int  deliveries = 0;
    int  first_req_cyc, first_vld_cyc;
    bit  exp_v;

    always @(negedge clk) begin
        if (rst) begin
            exp_req_pc     = RPC;
            exp_dlv_pc     = RPC;
            m_out          = 0;
            m_buf          = 0;
            stale          = 0;
            last_stale_cyc = 0;
            halted         = 1'b0;
            gap_wait       = 1'b0;
            first_req_cyc  = -1;
            first_vld_cyc  = -1;
        end else begin
            checks++;
            if (fetch_fault !== halted) begin
                errors++;
                $display("FAIL fault_flag cyc=%0d got=%0b exp=%0b", cyc, fetch_fault, halted);
            end
            exp_v = (m_buf > 0) && !redirect_valid && !halted;
            checks++;
            if (inst_valid !== exp_v) begin
                errors++;
                $display("FAIL inst_valid cyc=%0d got=%0b exp=%0b", cyc, inst_valid, exp_v);
            end
            if (halted) begin
                checks++;
                if (imem_req_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL halt_req cyc=%0d got=%0b exp=0", cyc, imem_req_valid);
                end
            end
            if (imem_req_valid && first_req_cyc < 0) first_req_cyc = cyc;
            if (inst_valid && first_vld_cyc < 0) first_vld_cyc = cyc;
            if (gap_wait && imem_req_valid) begin
                gap_wait = 1'b0;
                checks++;
                if (cyc != last_stale_cyc + 1) begin
                    errors++;
                    $display("FAIL redirect_gap cyc=%0d got_req_cyc=%0d exp=%0d", cyc, cyc, last_stale_cyc + 1);
                end
            end
            if (imem_req_valid && imem_req_ready) begin
                checks++;
                if (imem_req_addr !== exp_req_pc || stale > 0) begin
                    errors++;
                    $display("FAIL req_addr cyc=%0d got=%h exp=%h stale=%0d", cyc, imem_req_addr, exp_req_pc, stale);
                end
                exp_req_pc = exp_req_pc + 32'd4;
                m_out++;
            end
            if (inst_valid && inst_ready) begin
                checks++;
                if (inst_pc !== exp_dlv_pc || inst_data !== mem_word(exp_dlv_pc)) begin
                    errors++;
                    $display("FAIL deliver cyc=%0d got pc=%h data=%h exp pc=%h data=%h",
                             cyc, inst_pc, inst_data, exp_dlv_pc, mem_word(exp_dlv_pc));
                end
                exp_dlv_pc = exp_dlv_pc + 32'd4;
                m_buf--;
                deliveries++;
            end
            if (imem_resp_valid) begin
                m_out--;
                if (stale > 0) begin
                    stale--;
                    if (stale == 0) last_stale_cyc = cyc;
                end else if (!halted) begin
                    m_buf++;
                end
            end
            if (redirect_valid && !halted) begin
                m_buf = 0;
                if (redirect_pc[1:0] != 2'b00) begin
                    halted   = 1'b1;
                    gap_wait = 1'b0;
                end else begin
                    exp_req_pc = redirect_pc;
                    exp_dlv_pc = redirect_pc;
                    stale      = m_out;
                    gap_wait   = 1'b1;
                    if (m_out == 0) last_stale_cyc = cyc;
                end
            end
            checks++;
            if (m_out + m_buf > DEPTH) begin
                errors++;
                $display("FAIL credit_cap cyc=%0d got=%0d exp<=%0d", cyc, m_out + m_buf, DEPTH);
            end
        end
    end

    // ---------------- scenarios ----------------
    task automatic test_reset();
        int rel;
        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL rst_req_valid got=%0b exp=0", imem_req_valid); end
        checks++; if (imem_req_addr !== RPC) begin errors++; $display("FAIL rst_req_addr got=%h exp=%h", imem_req_addr, RPC); end
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL rst_inst_valid got=%0b exp=0", inst_valid); end
        checks++; if (inst_data !== 32'h0) begin errors++; $display("FAIL rst_inst_data got=%h exp=0", inst_data); end
        checks++; if (inst_pc !== 32'h0) begin errors++; $display("FAIL rst_inst_pc got=%h exp=0", inst_pc); end
        checks++; if (fetch_fault !== 1'b0) begin errors++; $display("FAIL rst_fault got=%0b exp=0", fetch_fault); end
        @(posedge clk); #2;
        rst = 1'b0; rel = cyc;
        repeat (5) @(posedge clk);
        #2;
        checks++; if (first_req_cyc != rel) begin errors++; $display("FAIL first_req got=%0d exp=%0d", first_req_cyc, rel); end
        checks++; if (first_vld_cyc != rel + 2) begin errors++; $display("FAIL first_valid got=%0d exp=%0d", first_vld_cyc, rel + 2); end
    endtask

    task automatic test_stream();
        int d0;
        lat_min = 1; lat_max = 1; rand_ready = 1'b0; inst_ready = 1'b1;
        d0 = deliveries;
        repeat (20) @(posedge clk);
        #2;
        checks++; if (deliveries - d0 != 20) begin errors++; $display("FAIL throughput got=%0d exp=20", deliveries - d0); end
    endtask

    task automatic test_stall();
        int d0;
        @(posedge clk); #2; inst_ready = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        checks++; if (inst_valid !== 1'b1) begin errors++; $display("FAIL stall_valid got=%0b exp=1", inst_valid); end
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL stall_req got=%0b exp=0", imem_req_valid); end
        d0 = deliveries;
        inst_ready = 1'b1;
        repeat (10) @(posedge clk);
        #2;
        checks++; if (deliveries - d0 != 10) begin errors++; $display("FAIL stall_release got=%0d exp=10", deliveries - d0); end
    endtask

    task automatic test_redirect_drain();
        bit found = 1'b0;
        int nresp = 0;
        int freq  = -1;
        lat_min = 3; lat_max = 3;
        for (int i = 0; i < 40 && !found; i++) begin
            @(posedge clk); #2;
            if (m_out == 2 && !imem_resp_valid) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++; $display("FAIL drain_setup got=timeout exp=two_outstanding");
        end else begin
            redirect_valid = 1'b1; redirect_pc = 32'h0000_0100;
            @(posedge clk); #2;
            redirect_valid = 1'b0;
            for (int i = 0; i < 30 && freq < 0; i++) begin
                if (imem_req_valid) begin
                    freq = cyc;
                    checks++;
                    if (imem_req_addr !== 32'h100) begin errors++; $display("FAIL drain_addr got=%h exp=00000100", imem_req_addr); end
                end else begin
                    if (imem_resp_valid) nresp++;
                    @(posedge clk); #2;
                end
            end
            checks++; if (nresp != 2) begin errors++; $display("FAIL drain_stale got=%0d exp=2", nresp); end
            checks++; if (freq != last_stale_cyc + 1) begin errors++; $display("FAIL drain_resume got=%0d exp=%0d", freq, last_stale_cyc + 1); end
            found = 1'b0;
            for (int i = 0; i < 30 && !found; i++) begin
                @(posedge clk); #2;
                if (inst_valid) found = 1'b1;
            end
            checks++; if (!found || inst_pc !== 32'h100) begin errors++; $display("FAIL drain_first_pc got=%h exp=00000100", inst_pc); end
        end
    endtask

    task automatic test_redirect_collide();
        bit found = 1'b0;
        int rc;
        int freq = -1;
        lat_min = 1; lat_max = 1;
        @(posedge clk); #2;
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0180;
        @(posedge clk); #2;
        redirect_valid = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (imem_resp_valid && imem_req_valid && imem_req_ready && !inst_valid) found = 1'b1;
            else begin @(posedge clk); #2; end
        end
        checks++;
        if (!found) begin
            errors++; $display("FAIL collide_setup got=timeout exp=resp_and_req");
        end else begin
            redirect_valid = 1'b1; redirect_pc = 32'h0000_0200; rc = cyc;
            @(posedge clk); #2;
            redirect_valid = 1'b0;
            for (int i = 0; i < 20 && freq < 0; i++) begin
                if (imem_req_valid) freq = cyc;
                else begin @(posedge clk); #2; end
            end
            checks++; if (freq != rc + 2) begin errors++; $display("FAIL collide_resume got=%0d exp=%0d", freq, rc + 2); end
            checks++; if (imem_req_addr !== 32'h200) begin errors++; $display("FAIL collide_addr got=%h exp=00000200", imem_req_addr); end
            found = 1'b0;
            for (int i = 0; i < 20 && !found; i++) begin
                if (inst_valid) found = 1'b1;
                else begin @(posedge clk); #2; end
            end
            checks++; if (!found || inst_pc !== 32'h200) begin errors++; $display("FAIL collide_first_pc got=%h exp=00000200", inst_pc); end
        end
    endtask

    task automatic test_random();
        int d0;
        lat_min = 1; lat_max = 4; rand_ready = 1'b1;
        d0 = deliveries;
        for (int i = 0; i < 600; i++) begin
            @(posedge clk); #2;
            inst_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) begin
                redirect_valid = 1'b1;
                redirect_pc    = $urandom & 32'h0000_FFFC;
            end else begin
                redirect_valid = 1'b0;
            end
        end
        @(posedge clk); #2;
        redirect_valid = 1'b0; inst_ready = 1'b1; rand_ready = 1'b0; lat_min = 1; lat_max = 1;
        checks++; if (deliveries - d0 < 50) begin errors++; $display("FAIL random_progress got=%0d exp>=50", deliveries - d0); end
    endtask

    task automatic test_fault();
        int seen = 0;
        repeat (4) @(posedge clk);
        #2;
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0102;
        @(posedge clk); #2;
        redirect_valid = 1'b0;
        checks++; if (fetch_fault !== 1'b1) begin errors++; $display("FAIL fault_set got=%0b exp=1", fetch_fault); end
        for (int i = 0; i < 10; i++) begin
            if (imem_req_valid || inst_valid) seen++;
            @(posedge clk); #2;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL halt_quiet got=%0d exp=0", seen); end
        checks++; if (fetch_fault !== 1'b1) begin errors++; $display("FAIL fault_sticky got=%0b exp=1", fetch_fault); end
    endtask

    task automatic test_reset_midstream();
        int rel, d0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #2; rst = 1'b0;
        lat_min = 3; lat_max = 3;
        repeat (8) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL mid_req_valid got=%0b exp=0", imem_req_valid); end
        checks++; if (imem_req_addr !== RPC) begin errors++; $display("FAIL mid_req_addr got=%h exp=%h", imem_req_addr, RPC); end
        checks++; if (inst_valid !== 1'b0 || inst_data !== 32'h0 || inst_pc !== 32'h0) begin
            errors++; $display("FAIL mid_inst got v=%0b d=%h pc=%h exp 0", inst_valid, inst_data, inst_pc);
        end
        checks++; if (fetch_fault !== 1'b0) begin errors++; $display("FAIL mid_fault got=%0b exp=0", fetch_fault); end
        repeat (3) @(posedge clk);
        #2;
        lat_min = 1; lat_max = 1;
        rst = 1'b0; rel = cyc; d0 = deliveries;
        repeat (12) @(posedge clk);
        #2;
        checks++; if (first_req_cyc != rel) begin errors++; $display("FAIL mid_restart got=%0d exp=%0d", first_req_cyc, rel); end
        checks++; if (deliveries - d0 != 10) begin errors++; $display("FAIL mid_stream got=%0d exp=10", deliveries - d0); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect_drain();
        test_redirect_collide();
        test_random();
        test_fault();
        test_reset_midstream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
